// File: rtl/decode_operand_stage.sv
// Decode/operand stage: resolves source operands through an own-register/forwarding/reg-file priority chain and evaluates branches.
// Latency: one cycle from acceptance to the output register; forwarding, hazard and jump logic are combinational.
// Backpressure: down_stall freezes the output register; an unready forwarded operand stalls fetch and inserts a bubble.
module decode_operand_stage #(
    parameter int XLEN       = 32,
    parameter int READ_PORTS = 2,
    parameter int FWD_STAGES = 3,
    parameter int REG_ID_W   = 5
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic [XLEN-1:0]                in_pc,
    input  logic [READ_PORTS*REG_ID_W-1:0] in_rd_id,
    input  logic [READ_PORTS*XLEN-1:0]     in_rd_data,
    input  logic [READ_PORTS-1:0]          in_rd_need,
    input  logic [REG_ID_W-1:0]            in_wr_id,
    input  logic                           in_wr_ready,
    input  logic [XLEN-1:0]                in_wr_data,
    input  logic [1:0]                     in_br_mode,
    input  logic [XLEN-1:0]                in_br_target,
    input  logic [FWD_STAGES*REG_ID_W-1:0] fwd_id,
    input  logic [FWD_STAGES-1:0]          fwd_ready,
    input  logic [FWD_STAGES*XLEN-1:0]     fwd_data,
    input  logic                           down_stall,
    input  logic                           flush,
    output logic                           in_ready,
    output logic                           out_valid,
    output logic [XLEN-1:0]                out_pc,
    output logic [READ_PORTS*XLEN-1:0]     out_op_data,
    output logic [REG_ID_W-1:0]            out_wr_id,
    output logic                           out_wr_ready,
    output logic [XLEN-1:0]                out_wr_data,
    output logic                           jump_en,
    output logic [XLEN-1:0]                jump_target,
    output logic [15:0]                    stall_count
);

    logic [READ_PORTS*XLEN-1:0] opData;
    logic [READ_PORTS-1:0]      hazard;
    logic [READ_PORTS-1:0]      matched;
    logic                       localStall;
    logic [XLEN-1:0]            op0;
    logic [XLEN-1:0]            op1;
    logic                       brTaken;
    logic                       captureValid;

    // First matching source wins: own output register, then youngest to oldest forward, then reg file.
    always_comb begin
        opData  = '0;
        hazard  = '0;
        matched = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            if (in_rd_id[p*REG_ID_W +: REG_ID_W] != '0) begin
                if (out_valid && (out_wr_id == in_rd_id[p*REG_ID_W +: REG_ID_W])) begin
                    matched[p]             = 1'b1;
                    hazard[p]              = !out_wr_ready;
                    opData[p*XLEN +: XLEN] = out_wr_data;
                end
                for (int s = 0; s < FWD_STAGES; s++) begin
                    if (!matched[p] && (fwd_id[s*REG_ID_W +: REG_ID_W] == in_rd_id[p*REG_ID_W +: REG_ID_W])) begin
                        matched[p]             = 1'b1;
                        hazard[p]              = !fwd_ready[s];
                        opData[p*XLEN +: XLEN] = fwd_data[s*XLEN +: XLEN];
                    end
                end
                if (!matched[p]) begin
                    opData[p*XLEN +: XLEN] = in_rd_data[p*XLEN +: XLEN];
                end
            end
        end
    end

    assign op0 = opData[XLEN-1:0];

    generate
        if (READ_PORTS > 1) begin : gOp1
            assign op1 = opData[2*XLEN-1:XLEN];
        end else begin : gOp1Zero
            assign op1 = '0;
        end
    endgenerate

    always_comb begin
        brTaken = 1'b0;
        case (in_br_mode)
            2'b01:   brTaken = 1'b1;
            2'b10:   brTaken = (op0 == op1);
            2'b11:   brTaken = (op0 != op1);
            default: brTaken = 1'b0;
        endcase
    end

    assign localStall   = in_valid && |(in_rd_need & hazard);
    assign in_ready     = !(localStall || down_stall);
    assign jump_en      = in_valid && in_ready && !flush && brTaken;
    assign jump_target  = in_br_target;
    assign captureValid = in_valid && !localStall;

    always_ff @(posedge clock) begin
        if (!reset) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_op_data  <= '0;
            out_wr_id    <= '0;
            out_wr_ready <= 1'b0;
            out_wr_data  <= '0;
            stall_count  <= '0;
        end else begin
            if (localStall && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
            // Flush only kills the valid bit; stale data fields are harmless behind out_valid=0.
            if (flush) begin
                out_valid <= 1'b0;
            end else if (!down_stall) begin
                out_valid <= captureValid;
                if (captureValid) begin
                    out_pc       <= in_pc;
                    out_op_data  <= opData;
                    out_wr_id    <= in_wr_id;
                    out_wr_ready <= in_wr_ready;
                    out_wr_data  <= in_wr_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_decode_operand_stage.sv
// Directed bench for decode_operand_stage with default parameters (XLEN=32, 2 read ports, 3 forward stages).
module tb_decode_operand_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [9:0]  in_rd_id;
    logic [63:0] in_rd_data;
    logic [1:0]  in_rd_need;
    logic [4:0]  in_wr_id;
    logic        in_wr_ready;
    logic [31:0] in_wr_data;
    logic [1:0]  in_br_mode;
    logic [31:0] in_br_target;
    logic [14:0] fwd_id;
    logic [2:0]  fwd_ready;
    logic [95:0] fwd_data;
    logic        down_stall;
    logic        flush;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [63:0] out_op_data;
    logic [4:0]  out_wr_id;
    logic        out_wr_ready;
    logic [31:0] out_wr_data;
    logic        jump_en;
    logic [31:0] jump_target;
    logic [15:0] stall_count;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clock = ~clock;

    decode_operand_stage #(
        .XLEN(32), .READ_PORTS(2), .FWD_STAGES(3), .REG_ID_W(5)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_pc(in_pc),
        .in_rd_id(in_rd_id), .in_rd_data(in_rd_data), .in_rd_need(in_rd_need),
        .in_wr_id(in_wr_id), .in_wr_ready(in_wr_ready), .in_wr_data(in_wr_data),
        .in_br_mode(in_br_mode), .in_br_target(in_br_target),
        .fwd_id(fwd_id), .fwd_ready(fwd_ready), .fwd_data(fwd_data),
        .down_stall(down_stall), .flush(flush),
        .in_ready(in_ready), .out_valid(out_valid), .out_pc(out_pc),
        .out_op_data(out_op_data), .out_wr_id(out_wr_id),
        .out_wr_ready(out_wr_ready), .out_wr_data(out_wr_data),
        .jump_en(jump_en), .jump_target(jump_target), .stall_count(stall_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_pc = '0; in_rd_id = '0; in_rd_data = '0;
        in_rd_need = '0; in_wr_id = '0; in_wr_ready = 1'b0; in_wr_data = '0;
        in_br_mode = 2'b00; in_br_target = '0; fwd_id = '0; fwd_ready = '0;
        fwd_data = '0; down_stall = 1'b0; flush = 1'b0;

        // Reset state
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_op_data", out_op_data, 0);
        check("rst_stall_count", stall_count, 0);

        // Register-file only: port1 id 2 -> 0x10, port0 id 1 -> 0x20
        reset = 1'b1;
        in_valid = 1'b1; in_pc = 32'h100;
        in_rd_id = {5'd2, 5'd1}; in_rd_data = {32'h10, 32'h20}; in_rd_need = 2'b11;
        @(negedge clock);
        check("rf_in_ready", in_ready, 1);
        step();
        check("rf_out_valid", out_valid, 1);
        check("rf_out_op_data", out_op_data, {32'h10, 32'h20});
        check("rf_out_pc", out_pc, 32'h100);

        // Priority: fwd[0] beats fwd[2]; then own output register beats both
        in_pc = 32'h104; in_rd_id = {5'd0, 5'd3};
        fwd_id = {5'd3, 5'd0, 5'd3}; fwd_data = {32'hB, 32'h0, 32'hA}; fwd_ready = 3'b111;
        in_wr_id = 5'd3; in_wr_ready = 1'b1; in_wr_data = 32'hC;
        step();
        check("prio_fwd0", out_op_data, 64'hA);
        check("prio_wr_id", out_wr_id, 3);
        in_pc = 32'h108; in_wr_id = 5'd0;
        step();
        check("prio_own_reg", out_op_data, 64'hC);

        // Load-use hazard on port 0
        fwd_id = {5'd0, 5'd0, 5'd4}; fwd_ready = 3'b110; fwd_data = {32'h0, 32'h0, 32'h44};
        in_rd_id = {5'd0, 5'd4}; in_rd_need = 2'b01; in_pc = 32'h10C;
        @(negedge clock);
        check("lu_in_ready", in_ready, 0);
        check("lu_jump_en", jump_en, 0);
        step();
        check("lu_bubble", out_valid, 0);
        check("lu_stall_count", stall_count, 1);
        fwd_ready = 3'b111;
        @(negedge clock);
        check("lu_release_in_ready", in_ready, 1);
        step();
        check("lu_accept_valid", out_valid, 1);
        check("lu_accept_op", out_op_data, 64'h44);
        check("lu_count_hold", stall_count, 1);

        // Branch: mode 10 with op0 == op1 == 5 through forwarding
        fwd_id = {5'd0, 5'd6, 5'd7}; fwd_data = {32'h0, 32'h5, 32'h5};
        in_rd_id = {5'd6, 5'd7}; in_rd_need = 2'b11; in_br_mode = 2'b10;
        in_br_target = 32'h400; in_pc = 32'h110;
        @(negedge clock);
        check("br_eq_jump_en", jump_en, 1);
        check("br_jump_target", jump_target, 32'h400);
        in_br_mode = 2'b11;
        #1;
        check("br_ne_equal_ops", jump_en, 0);
        in_br_mode = 2'b10; flush = 1'b1;
        #1;
        check("br_flush_jump_en", jump_en, 0);
        step();
        check("br_flush_out_valid", out_valid, 0);
        flush = 1'b0; in_br_mode = 2'b00;

        // Id 0 sources read as zero even when a forward stage carries id 0
        fwd_id = {5'd0, 5'd0, 5'd0}; fwd_data = {32'h0, 32'h0, 32'hFF};
        in_rd_id = {5'd0, 5'd0}; in_rd_data = {32'h99, 32'h77};
        in_pc = 32'h200; in_wr_id = 5'd9; in_wr_ready = 1'b1; in_wr_data = 32'h55;
        step();
        check("id0_op_zero", out_op_data, 0);
        check("id0_out_pc", out_pc, 32'h200);

        // Backpressure: three cycles of down_stall freeze the output register
        down_stall = 1'b1; in_pc = 32'h300; in_rd_id = {5'd0, 5'd1}; in_wr_id = 5'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("bp_in_ready", in_ready, 0);
            step();
            check("bp_out_pc_frozen", out_pc, 32'h200);
            check("bp_out_valid_frozen", out_valid, 1);
            check("bp_stall_count", stall_count, 1);
        end
        down_stall = 1'b0;

        // Saturation: hold a load-use hazard long enough to wrap a 16-bit counter
        fwd_id = {5'd0, 5'd0, 5'd4}; fwd_ready = 3'b110;
        in_rd_id = {5'd0, 5'd4}; in_rd_need = 2'b01;
        repeat (65540) @(posedge clock);
        #1;
        check("sat_stall_count", stall_count, 16'hFFFF);
        check("sat_out_valid", out_valid, 0);

        // Reset asserted mid-stall clears everything on that edge
        reset = 1'b0;
        step();
        check("rst2_out_valid", out_valid, 0);
        check("rst2_out_pc", out_pc, 0);
        check("rst2_out_op_data", out_op_data, 0);
        check("rst2_out_wr_id", out_wr_id, 0);
        check("rst2_out_wr_ready", out_wr_ready, 0);
        check("rst2_out_wr_data", out_wr_data, 0);
        check("rst2_stall_count", stall_count, 0);
        reset = 1'b1; fwd_ready = 3'b111; in_pc = 32'h500;
        @(negedge clock);
        check("post_rst_in_ready", in_ready, 1);
        step();
        check("post_rst_out_valid", out_valid, 1);
        check("post_rst_stall_count", stall_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
